// File: rtl/result_streamer.sv
// Drain side of the systolic array: snapshots the N*N accumulator tile on a
// capture pulse and streams it out row-major over a valid/ready port.
module result_streamer #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap,
  input  logic [N*N*DATA_W-1:0]      c_flat,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [IDX_W-1:0]           m_index,
  output logic                       m_last,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       clr_ovf,
  output logic [7:0]                 tile_count
);

  localparam int              DEPTH    = N * N;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_STREAM = 1'b1;

  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_ovf;
  logic [7:0]        r_tiles;

  logic              w_hs;
  logic              w_final;
  logic              w_load;
  logic              w_reject;
  logic [IDX_W-1:0]  w_next_idx;

  assign w_hs       = (r_state == ST_STREAM) && m_ready;
  assign w_final    = w_hs && (r_idx == LAST_IDX);
  // A capture is accepted when idle or on the edge that retires the last word.
  assign w_load     = cap && ((r_state == ST_IDLE) || w_final);
  assign w_reject   = cap && (r_state == ST_STREAM) && !w_final;
  assign w_next_idx = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_buf[k] <= c_flat[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_state <= ST_STREAM;
      r_idx   <= '0;
      r_data  <= c_flat[DATA_W-1:0];
      r_last  <= (DEPTH == 1);
    end else if (w_final) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (w_hs) begin
      // Word k+1 is fetched from the buffer on the edge that retires word k.
      r_idx   <= w_next_idx;
      r_data  <= r_buf[w_next_idx];
      r_last  <= (w_next_idx == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf   <= 1'b0;
      r_tiles <= '0;
    end else begin
      if (w_reject) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
      if (w_final) begin
        r_tiles <= r_tiles + 8'd1;
      end
    end
  end

  assign m_valid    = (r_state == ST_STREAM);
  assign busy       = (r_state == ST_STREAM);
  assign m_data     = r_data;
  assign m_index    = r_idx;
  assign m_last     = r_last;
  assign overrun    = r_ovf;
  assign tile_count = r_tiles;

endmodule

// File: tb/tb_result_streamer.sv
// Directed self-checking bench for result_streamer: drain, backpressure,
// rejected capture, back-to-back tiles, async reset and tile_count wrap.
module tb_result_streamer;

  localparam int N      = 4;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  logic                  clk;
  logic                  rst;
  logic                  cap;
  logic [N*N*DATA_W-1:0] c_flat;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_W-1:0]     m_data;
  logic [IDX_W-1:0]      m_index;
  logic                  m_last;
  logic                  busy;
  logic                  overrun;
  logic                  clr_ovf;
  logic [7:0]            tile_count;

  int n_vec = 0;
  int n_err = 0;

  result_streamer #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cap        (cap),
    .c_flat     (c_flat),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_last     (m_last),
    .busy       (busy),
    .overrun    (overrun),
    .clr_ovf    (clr_ovf),
    .tile_count (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("miscompare in %s", tag);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input logic [31:0] base, input bit down, input int k);
    return down ? base - 32'(k) : base + 32'(k);
  endfunction

  task automatic set_flat(input logic [31:0] base, input bit down);
    for (int k = 0; k < N*N; k++) c_flat[k*DATA_W +: DATA_W] = word(base, down, k);
  endtask

  task automatic start_tile(input logic [31:0] base, input bit down);
    set_flat(base, down);
    cap = 1'b1;
    tick;
    cap = 1'b0;
  endtask

  // Checks every beat of a tile already visible at beat 0. inj_at injects a
  // capture mid-stream; chain captures inj_base on the final handshake.
  task automatic drain(input logic [31:0] base, input bit down, input bit bp,
                       input int inj_at, input logic [31:0] inj_base, input bit chain);
    for (int b = 0; b < N*N; b++) begin
      chk("valid", 32'(m_valid), 32'd1);
      chk("busy",  32'(busy),    32'd1);
      chk("data",  m_data,       word(base, down, b));
      chk("index", 32'(m_index), 32'(b));
      chk("last",  32'(m_last),  32'(b == N*N-1));
      if (b == inj_at || (chain && b == N*N-1)) begin
        set_flat(inj_base, 1'b0);
        cap = 1'b1;
      end
      m_ready = 1'b1;
      tick;
      cap = 1'b0;
      if (bp && b < N*N-1) begin
        m_ready = 1'b0;
        tick;
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data",  m_data,       word(base, down, b+1));
        chk("hold_index", 32'(m_index), 32'(b+1));
        chk("hold_last",  32'(m_last),  32'(b+1 == N*N-1));
      end
    end
    if (!chain) begin
      chk("valid_after", 32'(m_valid), 32'd0);
      chk("busy_after",  32'(busy),    32'd0);
      chk("last_after",  32'(m_last),  32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; cap = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0; c_flat = '0;
    #3;
    chk("rst_valid", 32'(m_valid),  32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_index", 32'(m_index),  32'd0);
    chk("rst_last",  32'(m_last),   32'd0);
    chk("rst_data",  m_data,        32'd0);
    chk("rst_ovf",   32'(overrun),  32'd0);
    chk("rst_tiles", 32'(tile_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick;
    chk("idle_valid", 32'(m_valid), 32'd0);

    m_ready = 1'b1;
    start_tile(32'd100, 1'b0);
    drain(32'd100, 1'b0, 1'b0, -1, 32'd0, 1'b0);
    chk("basic_tiles", 32'(tile_count), 32'd1);
    $display("tile basic: 16 beats, tile_count=%0d", tile_count);

    m_ready = 1'b0;
    start_tile(32'd100, 1'b0);
    drain(32'd100, 1'b0, 1'b1, -1, 32'd0, 1'b0);
    chk("bp_tiles", 32'(tile_count), 32'd2);
    $display("tile backpressure: 16 beats over 31 cycles, tile_count=%0d", tile_count);

    m_ready = 1'b1;
    start_tile(32'd100, 1'b0);
    drain(32'd100, 1'b0, 1'b0, 5, 32'hAAAA0000, 1'b0);
    chk("ovf_set",   32'(overrun),    32'd1);
    chk("ovf_tiles", 32'(tile_count), 32'd3);
    clr_ovf = 1'b1; tick; clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overrun), 32'd0);
    $display("tile overrun: rejected capture flagged and cleared");

    start_tile(32'd100, 1'b0);
    drain(32'd100, 1'b0, 1'b0, -1, 32'd200, 1'b1);
    chk("b2b_tiles", 32'(tile_count), 32'd4);
    chk("b2b_ovf",   32'(overrun),    32'd0);
    drain(32'd200, 1'b0, 1'b0, -1, 32'd0, 1'b0);
    chk("b2b_tiles2", 32'(tile_count), 32'd5);
    $display("tile back-to-back: second tile without bubble, tile_count=%0d", tile_count);

    start_tile(32'd100, 1'b0);
    repeat (3) tick;
    cap = 1'b1; tick; cap = 1'b0;
    repeat (3) tick;
    chk("pre_rst_index", 32'(m_index), 32'd7);
    chk("pre_rst_ovf",   32'(overrun), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid),    32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    chk("arst_index", 32'(m_index),    32'd0);
    chk("arst_ovf",   32'(overrun),    32'd0);
    chk("arst_tiles", 32'(tile_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    start_tile(32'd300, 1'b0);
    drain(32'd300, 1'b0, 1'b0, -1, 32'd0, 1'b0);
    chk("post_rst_tiles", 32'(tile_count), 32'd1);
    $display("tile async reset: partial tile discarded, fresh tile ok");

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int t = 1; t <= 256; t++) begin
      start_tile(32'hFFFFFFFF, 1'b1);
      drain(32'hFFFFFFFF, 1'b1, 1'b0, -1, 32'd0, 1'b0);
      chk("wrap_tiles", 32'(tile_count), 32'(t % 256));
    end
    $display("tile wrap: 256 tiles drained, tile_count=%0d", tile_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
